// File: rtl/shift_exec_unit.sv
// Two-stage RV64 execute shift unit: operand prep in stage 1, shift and
// W-variant sign-extension in stage 2, valid/ready flow control throughout.
module shift_exec_unit #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int unsigned SHW  = $clog2(XLEN);
  localparam int unsigned HIGH = XLEN - 32;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  // stage 1 registers
  logic             s1_valid_q;
  logic [1:0]       s1_op_q;
  logic             s1_word_q;
  logic [XLEN-1:0]  s1_opnd_q, s1_opnd_d;
  logic [SHW-1:0]   s1_sh_q, s1_sh_d;
  logic [TAG_W-1:0] s1_tag_q;

  // stage 2 (output) registers
  logic             out_valid_q;
  logic [XLEN-1:0]  out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q;
  logic             out_illegal_q, out_illegal_d;

  logic adv1, adv2, in_accept;
  logic [XLEN-1:0] sra_v, raw_v;

  // Upper shift-amount bits are architecturally ignored.
  logic unused_rs2;
  assign unused_rs2 = ^in_rs2[XLEN-1:SHW];

  // Pipeline advance conditions; in_ready never looks at in_valid.
  assign adv2      = !out_valid_q || out_ready;
  assign adv1      = !s1_valid_q || adv2;
  assign in_ready  = adv1;
  assign in_accept = in_valid && adv1 && !flush;

  // Operand preparation and shift-amount masking for word variants.
  always_comb begin
    s1_opnd_d = in_rs1;
    s1_sh_d   = in_word ? SHW'(in_rs2[4:0]) : in_rs2[SHW-1:0];
    if (in_word && (in_op == OP_SRA)) begin
      s1_opnd_d = {{HIGH{in_rs1[31]}}, in_rs1[31:0]};
    end else if (in_word && (in_op == OP_SRL)) begin
      s1_opnd_d = {{HIGH{1'b0}}, in_rs1[31:0]};
    end
  end

  // Stage 1 register: capture on accept, hold while stage 2 is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= 2'b00;
      s1_word_q  <= 1'b0;
      s1_opnd_q  <= '0;
      s1_sh_q    <= '0;
      s1_tag_q   <= '0;
    end else begin
      if (flush) begin
        s1_valid_q <= 1'b0;
      end else if (adv1) begin
        s1_valid_q <= in_valid;
      end
      if (in_accept) begin
        s1_op_q   <= in_op;
        s1_word_q <= in_word;
        s1_opnd_q <= s1_opnd_d;
        s1_sh_q   <= s1_sh_d;
        s1_tag_q  <= in_tag;
      end
    end
  end

  // Log2(XLEN)-stage arithmetic barrel shifter core.
  always_comb begin
    sra_v = s1_opnd_q;
    for (int unsigned k = 0; k < SHW; k++) begin
      if (s1_sh_q[k]) begin
        sra_v = $signed(sra_v) >>> (1 << k);
      end
    end
  end

  // Shift select, W-variant sign-extension and reserved-op handling.
  always_comb begin
    out_illegal_d = 1'b0;
    case (s1_op_q)
      OP_SLL:  raw_v = s1_opnd_q << s1_sh_q;
      OP_SRL:  raw_v = s1_opnd_q >> s1_sh_q;
      OP_SRA:  raw_v = sra_v;
      default: raw_v = '0;
    endcase
    out_result_d = raw_v;
    if (s1_word_q) begin
      out_result_d = {{HIGH{raw_v[31]}}, raw_v[31:0]};
    end
    if (s1_op_q == 2'b11) begin
      out_result_d  = '0;
      out_illegal_d = 1'b1;
    end
  end

  // Output register: load when the consumer side can advance, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_tag_q     <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (adv2) begin
        out_valid_q <= s1_valid_q;
      end
      if (adv2 && s1_valid_q && !flush) begin
        out_result_q  <= out_result_d;
        out_tag_q     <= s1_tag_q;
        out_illegal_q <= out_illegal_d;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_tag     = out_tag_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_shift_exec_unit.sv
// Directed bench for shift_exec_unit: vector table plus flow-control sequences.
module tb_shift_exec_unit;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned NVEC  = 14;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic             in_word;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  typedef struct {
    logic [1:0]       op;
    logic             word;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  exp_res;
    logic             exp_ill;
  } vec_t;

  vec_t vecs [NVEC];
  int checks;
  int failures;

  shift_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_word    (in_word),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic word, input logic [63:0] rs1,
                       input logic [63:0] rs2, input logic [4:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_word  = word;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_tag   = tag;
  endtask

  // Issue one op with no backpressure and check it two edges later.
  task automatic apply_vec(input vec_t v, input int idx);
    out_ready = 1'b1;
    drive(v.op, v.word, v.rs1, v.rs2, v.tag);
    #1;
    chk($sformatf("v%0d_in_ready", idx), 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk($sformatf("v%0d_valid_early", idx), 64'(out_valid), 64'd0);
    step();
    chk($sformatf("v%0d_valid", idx), 64'(out_valid), 64'd1);
    chk($sformatf("v%0d_result", idx), out_result, v.exp_res);
    chk($sformatf("v%0d_tag", idx), 64'(out_tag), 64'(v.tag));
    chk($sformatf("v%0d_illegal", idx), 64'(out_illegal), 64'(v.exp_ill));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;

    //        op     word  rs1                     rs2                     tag    expected                ill
    vecs[0]  = '{2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'd63,                5'd7,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[1]  = '{2'b10, 1'b1, 64'h0000_0000_8000_0000, 64'd4,                 5'd1,  64'hFFFF_FFFF_F800_0000, 1'b0};
    vecs[2]  = '{2'b01, 1'b1, 64'h0000_0000_8000_0000, 64'd4,                 5'd2,  64'h0000_0000_0800_0000, 1'b0};
    vecs[3]  = '{2'b00, 1'b1, 64'd1,                   64'd31,                5'd3,  64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[4]  = '{2'b00, 1'b0, 64'd1,                   64'hFFFF_FFFF_FFFF_FF41, 5'd4, 64'h2,                 1'b0};
    vecs[5]  = '{2'b00, 1'b1, 64'd1,                   64'h21,                5'd5,  64'h2,                   1'b0};
    vecs[6]  = '{2'b01, 1'b0, 64'hF0,                  64'd0,                 5'd6,  64'hF0,                  1'b0};
    vecs[7]  = '{2'b11, 1'b0, 64'h1234,                64'd4,                 5'd8,  64'h0,                   1'b1};
    vecs[8]  = '{2'b10, 1'b0, 64'h1234,                64'd4,                 5'd9,  64'h123,                 1'b0};
    vecs[9]  = '{2'b10, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'd0,                 5'd10, 64'hFFFF_FFFF_9ABC_DEF0, 1'b0};
    vecs[10] = '{2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'd63,                5'd11, 64'h1,                   1'b0};
    vecs[11] = '{2'b00, 1'b0, 64'hFF,                  64'd60,                5'd12, 64'hF000_0000_0000_0000, 1'b0};
    vecs[12] = '{2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                 5'd13, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[13] = '{2'b10, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd63,                5'd14, 64'h0,                   1'b0};

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_word   = 1'b0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_illegal", 64'(out_illegal), 64'd0);
    #10;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    step();

    // Vector table, including reserved op followed by a legal SRA
    for (int i = 0; i < NVEC; i++) begin
      apply_vec(vecs[i], i);
    end
    step();
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: tags 1,2,3 issued with the consumer stalled
    out_ready = 1'b0;
    drive(2'b00, 1'b0, 64'd1, 64'd1, 5'd1);
    step();
    drive(2'b00, 1'b0, 64'd1, 64'd2, 5'd2);
    chk("bp_ready_t2", 64'(in_ready), 64'd1);
    step();
    drive(2'b00, 1'b0, 64'd1, 64'd3, 5'd3);
    chk("bp_ready_t3_blocked", 64'(in_ready), 64'd0);
    chk("bp_head_valid", 64'(out_valid), 64'd1);
    chk("bp_head_tag", 64'(out_tag), 64'd1);
    step();
    chk("bp_hold1_ready", 64'(in_ready), 64'd0);
    chk("bp_hold1_tag", 64'(out_tag), 64'd1);
    chk("bp_hold1_result", out_result, 64'd2);
    step();
    chk("bp_hold2_tag", 64'(out_tag), 64'd1);
    chk("bp_hold2_result", out_result, 64'd2);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_o2_valid", 64'(out_valid), 64'd1);
    chk("bp_o2_tag", 64'(out_tag), 64'd2);
    chk("bp_o2_result", out_result, 64'd4);
    step();
    chk("bp_o3_valid", 64'(out_valid), 64'd1);
    chk("bp_o3_tag", 64'(out_tag), 64'd3);
    chk("bp_o3_result", out_result, 64'd8);
    step();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush with two ops in flight plus one presented in the flush cycle
    out_ready = 1'b0;
    drive(2'b00, 1'b0, 64'd1, 64'd5, 5'd16);
    step();
    drive(2'b00, 1'b0, 64'd1, 64'd6, 5'd17);
    step();
    chk("fl_pre_valid", 64'(out_valid), 64'd1);
    chk("fl_pre_tag", 64'(out_tag), 64'd16);
    flush     = 1'b1;
    out_ready = 1'b1;
    drive(2'b00, 1'b0, 64'd1, 64'd7, 5'd18);
    #1;
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_post_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("fl_quiet%0d", i), 64'(out_valid), 64'd0);
    end

    // Asynchronous reset mid-stream
    out_ready = 1'b1;
    drive(2'b00, 1'b0, 64'd1, 64'd3, 5'd20);
    step();
    drive(2'b00, 1'b0, 64'd1, 64'd4, 5'd21);
    step();
    in_valid = 1'b0;
    chk("ar_pre_valid", 64'(out_valid), 64'd1);
    chk("ar_pre_result", out_result, 64'd8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_result", out_result, 64'd0);
    chk("ar_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ar_no_ghost", 64'(out_valid), 64'd0);
    apply_vec(vecs[8], 100);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_exec_unit.md
Name: shift_exec_unit

Overview:
- Two-stage pipelined RV64 execute-stage shift unit: accepts decoded shift operations from the issue stage and drives the combinational arithmetic/logical shifter cores.
- Handles operand preparation, RV64 word (W) variants, result sign-extension and valid/ready flow control.
- Returns results, with an opaque tag, to the writeback arbiter.
- Throughput 1 op/cycle; latency 2 cycles when unstalled.

Parameters:
XLEN, 64, datapath width; must be a power of two, at least 64; word variants operate on the low 32 bits.
TAG_W, 5, width of the opaque tag (destination register index) carried alongside each op.

Ports:
clk  input  1  clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous pipeline kill; invalidates all in-flight ops.
in_valid  input  1  op presented.
in_ready  output  1  unit can accept op this cycle.
in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved.
in_word  input  1  1 = W variant (SLLW/SRLW/SRAW).
in_rs1  input  XLEN  value to be shifted.
in_rs2  input  XLEN  shift-amount source (register or immediate).
in_tag  input  TAG_W  passthrough tag.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
out_result  output  XLEN  shifted result.
out_tag  output  TAG_W  tag of the op producing out_result.
out_illegal  output  1  op was reserved encoding 11.

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, out_valid=0, out_result=0, out_tag=0, out_illegal=0. in_ready reads 1 immediately after reset release.
- Handshakes:
  - Transfer on in_valid&&in_ready and on out_valid&&out_ready.
  - out_result/out_tag/out_illegal must hold stable while out_valid&&!out_ready.
- Flow control:
  - adv2 = !out_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1, a combinational function of the registered state and out_ready only; it does not depend on in_valid.
- Stage 1 (registered on in accept):
  - Shift amount: sh = in_rs2[5:0], or in_rs2[4:0] zero-extended when in_word=1. Upper bits of in_rs2 are ignored.
  - Operand:
    - Non-word ops: in_rs1 unchanged.
    - SRAW: in_rs1[31:0] sign-extended.
    - SRLW: in_rs1[31:0] zero-extended.
    - SLLW: in_rs1 unchanged.
- Stage 2 (registered into out_* when adv2):
  - SLL: operand << sh.
  - SRL: logical right shift by sh.
  - SRA: arithmetic right shift by sh, via the $clog2(XLEN)-stage barrel shifter core.
  - W variants: final result = sign-extension of bit 31 of the 64-bit shift result into the upper 32 bits.
  - Reserved op 11: out_result=0, out_illegal=1; tag passes through. Otherwise out_illegal=0.
- Stall: s1 holds when !adv2. A new op is accepted into s1 in the same cycle s1 drains into stage 2, so there are no bubbles at full throughput.
- flush:
  - Clears s1_valid and out_valid next edge, regardless of out_ready.
  - An op presented in the same cycle as flush is dropped; in_ready may be 1, but the op is not captured.
  - out_result is not required to clear.
- Shift by 0 returns the prepared operand unchanged; for W ops this is the sign-extended low word.
- Op ordering is strictly preserved; there is no reordering or duplication.
- Reset asserted mid-operation discards all in-flight ops asynchronously; outputs take their reset values within the same cycle.

Test Plan:
- SRA in_rs1=0x8000_0000_0000_0000, in_rs2=63 -> out_result=0xFFFF_FFFF_FFFF_FFFF; out_valid rises 2 cycles after accept; out_tag matches in_tag.
- W ops with in_rs1=0x0000_0000_8000_0000, in_rs2=4:
  - SRAW -> 0xFFFF_FFFF_F800_0000.
  - SRLW -> 0x0000_0000_0800_0000.
  - SLLW in_rs1=1, in_rs2=31 -> 0xFFFF_FFFF_8000_0000.
- Amount masking:
  - SLL in_rs1=1, in_rs2=0xFFFF_FFFF_FFFF_FF41 -> 0x2.
  - SLLW in_rs1=1, in_rs2=0x21 -> 0x2.
  - SRL in_rs1=0xF0, in_rs2=0 -> 0xF0.
- Backpressure:
  - Stimulus: out_ready=0 while issuing tags 1,2,3 back-to-back.
  - Required: tags 1 and 2 accepted, then in_ready=0; outputs stable while stalled.
  - Then raise out_ready: results emerge in order 1,2,3 on consecutive cycles with no bubbles.
- Reserved op 11, in_rs1=0x1234 -> out_illegal=1, out_result=0; the next valid SRA op yields out_illegal=0.
- Flush with two ops in flight -> out_valid=0 next cycle and neither result appears. Reset pulsed low mid-stream -> out_valid drops asynchronously; a fresh op after release completes correctly in 2 cycles.
